map_framebuffer_arbiter: RTL
============================

Name: map_framebuffer_arbiter

Overview:
- Owns the single-port occupancy-map frame memory and shares it between two requesters: the display pixel fetch feeding the VGA driver, and the SLAM map-update writer.
- Display fetch has absolute priority inside the visible map window. Writer updates and a bulk clear engine use the remaining slots.
- Runs in the pixel clock domain and takes the VGA timing counters as its schedule.

Parameters:
- MAP_W, 400, map width in cells
- MAP_H, 225, map height in cells
- SHIFT, 2, log2 of screen pixels per map cell per axis (400<<2 = 1600, 225<<2 = 900)
- ADDR_W, 17, memory address width; must satisfy MAP_W*MAP_H <= 2^ADDR_W
- DATA_W, 12, cell / RGB width
- RD_LAT, 1, memory read latency in cycles (mem_addr registered to mem_rdata valid)
- BORDER, 12'h000, rgb_out value outside the map window
- CLR_VALUE, 12'h777, value written by the clear engine

Ports:
- clock  in  1  pixel clock; single clock for the block
- reset  in  1  asynchronous, active-low reset
- h_cntr  in  14  horizontal pixel counter
- v_cntr  in  14  vertical line counter
- rgb_out  out  DATA_W  pixel colour, LAT cycles after the h/v sample
- wr_req  in  1  writer request (level)
- wr_addr  in  ADDR_W  writer cell address
- wr_data  in  DATA_W  writer cell value
- wr_ack  out  1  one-cycle acceptance pulse
- clr_start  in  1  pulse that starts a full-map clear
- clr_busy  out  1  high while a clear is in progress
- mem_en  out  1  memory enable (registered)
- mem_we  out  1  memory write enable (registered)
- mem_addr  out  ADDR_W  memory address (registered)
- mem_wdata  out  DATA_W  memory write data (registered)
- mem_rdata  in  DATA_W  memory read data

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs go to 0, including rgb_out.
  - FSM goes to IDLE; clear counter goes to 0; all pipeline valid bits are cleared.
- Display window: disp = (h_cntr < MAP_W<<SHIFT) && (v_cntr < MAP_H<<SHIFT).
- Display cell address: (v_cntr>>SHIFT)*MAP_W + (h_cntr>>SHIFT), truncated to ADDR_W.
- Display read:
  - Every cycle with disp=1 registers a read: mem_en=1, mem_we=0, mem_addr=cell address. The slot always belongs to the display.
- Display pipeline and latency:
  - LAT = RD_LAT+2 (address register, memory, output register).
  - A disp flag travels down a LAT-deep shift register alongside the read.
  - rgb_out = mem_rdata when the delayed flag is 1, otherwise BORDER.
  - The top level feeds counters that lead the VGA driver by LAT.
- Free slot: a cycle with disp=0. In a free slot, one of the following happens, in priority order:
  1. CLEAR write
  2. writer write
  3. mem_en=0
- FSM states:
  - IDLE:
    - clr_start=1 → CLEAR, counter=0, clr_busy=1 on the next edge.
    - Otherwise, if wr_req=1 in a free slot and wr_ack=0 this cycle, accept the write.
  - CLEAR:
    - Each free slot issues a write of CLR_VALUE to the counter address, then increments the counter.
    - The write to address MAP_W*MAP_H-1 → IDLE; clr_busy falls on the same edge that registers that write.
    - clr_start is ignored while in CLEAR.
    - wr_req is not acked while in CLEAR.
- Writer handshake:
  - On acceptance, the next edge registers mem_we=1, mem_addr=wr_addr, mem_wdata=wr_data and wr_ack=1 for exactly one cycle.
  - The writer holds addr/data stable until it sees wr_ack. It may keep wr_req high for the next write.
  - No write is accepted in a cycle where wr_ack=1 (turnaround), so the peak rate is one write per 2 cycles.
- Out-of-range writes: wr_addr >= MAP_W*MAP_H is still acked, with mem_en=mem_we=0 (dropped).
- Simultaneous events:
  - clr_start and an acceptable wr_req in the same IDLE free cycle: the clear wins, and the write waits until the clear ends.
  - A display cycle always stalls both the clear and the writer.
- Reset during a clear aborts it. The map is left partially cleared, clr_busy=0.

Test Plan:
- Reset with reset=0 mid-frame → rgb_out=0, mem_en=0, mem_we=0, wr_ack=0, clr_busy=0. Release, then h=0,v=0 → mem_addr=0, mem_en=1 one edge later.
- Address mapping:
  - h=5,v=9 → mem_addr=2*400+1=801.
  - h=1599,v=899 → mem_addr=89999.
  - Memory model returns mem_rdata=addr[11:0] → rgb_out matches exactly LAT=3 cycles after the sample.
  - h=1600 → rgb_out=BORDER after 3 cycles.
- Writer stalled by display: wr_req=1 with wr_addr=123, wr_data=12'hABC while h<1600 → no ack. At first h=1600: wr_ack pulses, mem_we=1, mem_addr=123, mem_wdata=12'hABC. Back-to-back requests → acks spaced ≥2 cycles.
- Out-of-range write: wr_addr=90000 in blanking → wr_ack=1, mem_we=0.
- Clear:
  - clr_start in blanking → exactly 90000 CLR_VALUE writes covering addresses 0..89999, each once.
  - None of the writes occur with disp=1; no wr_ack while clr_busy=1.
  - A second clr_start mid-clear is ignored.
  - clr_busy falls with the last write.
- Collision and reset abort:
  - clr_start and wr_req in the same cycle → the clear runs first; the write is acked after clr_busy falls.
  - Assert reset mid-clear → clr_busy=0 immediately (asynchronous). After release, the FSM is in IDLE and a new clear restarts at address 0.

Source files
------------

// File: rtl/map_framebuffer_arbiter.sv
// Occupancy-map frame memory arbiter.
// Shares one single-port memory between the display pixel fetch, the SLAM map
// writer and a bulk clear engine. Inside the visible map window every memory
// slot is a display read. Cycles outside the window are free slots, and the
// clear engine and then the writer use them.
//
// Ports:
//   clock, reset         pixel clock, asynchronous active-low reset
//   h_cntr, v_cntr       VGA timing counters, leading the driver by LAT cycles
//   rgb_out              pixel colour, LAT cycles after the counter sample
//   wr_req/addr/data     writer request; held stable until wr_ack
//   wr_ack               one-cycle acceptance pulse
//   clr_start, clr_busy  full-map clear trigger and status
//   mem_*                registered single-port memory interface
module map_framebuffer_arbiter #(
    parameter int unsigned        MAP_W     = 400,
    parameter int unsigned        MAP_H     = 225,
    parameter int unsigned        SHIFT     = 2,
    parameter int unsigned        ADDR_W    = 17,
    parameter int unsigned        DATA_W    = 12,
    parameter int unsigned        RD_LAT    = 1,
    parameter logic [DATA_W-1:0]  BORDER    = '0,
    parameter logic [DATA_W-1:0]  CLR_VALUE = 12'h777
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [13:0]       h_cntr,
    input  logic [13:0]       v_cntr,
    output logic [DATA_W-1:0] rgb_out,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    input  logic              clr_start,
    output logic              clr_busy,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int unsigned LAT    = RD_LAT + 2;
    localparam int unsigned CELLS  = MAP_W * MAP_H;
    localparam int unsigned SCR_W  = MAP_W << SHIFT;
    localparam int unsigned SCR_H  = MAP_H << SHIFT;
    // Flag stages up to the point where mem_rdata is valid; rgb_out is the last stage.
    localparam int unsigned PIPE_D = LAT - 1;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   clr_cnt, clr_cnt_nxt;
    logic [PIPE_D-1:0]   disp_pipe;
    logic                disp;
    logic [ADDR_W-1:0]   disp_addr;
    logic                en_nxt, we_nxt, ack_nxt;
    logic [ADDR_W-1:0]   addr_nxt;
    logic [DATA_W-1:0]   wdata_nxt;

    // Visible-window test and cell address of the current counter sample.
    assign disp      = (32'(h_cntr) < SCR_W) && (32'(v_cntr) < SCR_H);
    assign disp_addr = ADDR_W'(32'(v_cntr >> SHIFT) * MAP_W + 32'(h_cntr >> SHIFT));

    // Slot arbitration and next-state logic.
    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        en_nxt      = 1'b0;
        we_nxt      = 1'b0;
        ack_nxt     = 1'b0;
        addr_nxt    = mem_addr;
        wdata_nxt   = mem_wdata;

        if (disp) begin
            en_nxt   = 1'b1;
            addr_nxt = disp_addr;
        end

        unique case (state)
            IDLE: begin
                if (clr_start) begin
                    state_nxt   = CLEAR;
                    clr_cnt_nxt = '0;
                end else if (!disp && wr_req && !wr_ack) begin
                    // Out-of-range writes are acknowledged but never reach memory.
                    ack_nxt = 1'b1;
                    if (32'(wr_addr) < CELLS) begin
                        en_nxt    = 1'b1;
                        we_nxt    = 1'b1;
                        addr_nxt  = wr_addr;
                        wdata_nxt = wr_data;
                    end
                end
            end
            CLEAR: begin
                if (!disp) begin
                    en_nxt    = 1'b1;
                    we_nxt    = 1'b1;
                    addr_nxt  = clr_cnt;
                    wdata_nxt = CLR_VALUE;
                    if (32'(clr_cnt) == CELLS - 1) begin
                        state_nxt = IDLE;
                    end else begin
                        clr_cnt_nxt = clr_cnt + ADDR_W'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, memory port and handshake registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            clr_cnt   <= '0;
            clr_busy  <= 1'b0;
            wr_ack    <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state     <= state_nxt;
            clr_cnt   <= clr_cnt_nxt;
            clr_busy  <= (state_nxt == CLEAR);
            wr_ack    <= ack_nxt;
            mem_en    <= en_nxt;
            mem_we    <= we_nxt;
            mem_addr  <= addr_nxt;
            mem_wdata <= wdata_nxt;
        end
    end

    // Display flag travels alongside the read so rgb_out knows whether to show data.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            disp_pipe <= '0;
            rgb_out   <= '0;
        end else begin
            disp_pipe[0] <= disp;
            for (int i = 1; i < int'(PIPE_D); i++) begin
                disp_pipe[i] <= disp_pipe[i-1];
            end
            rgb_out <= disp_pipe[PIPE_D-1] ? mem_rdata : BORDER;
        end
    end

endmodule
